// File: rtl/mc_pkg.sv
// Shared encodings for the RV32I multicycle controller: FSM states, opcodes,
// datapath mux selects, ALU controls and the immediate-format decode.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADR    = 4'd2,
    S_MEMREAD   = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWRITE  = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALUWB     = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_JALR      = 4'd11,
    S_JALR_LINK = 4'd12
  } state_e;

  typedef enum logic [1:0] {
    FN_ADD   = 2'd0,
    FN_SUB   = 2'd1,
    FN_FUNCT = 2'd2
  } alu_fn_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format depends only on the opcode, independent of FSM state.
  function automatic logic [1:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_STORE:  imm_sel = IMM_S;
      OP_BRANCH: imm_sel = IMM_B;
      OP_JAL:    imm_sel = IMM_J;
      default:   imm_sel = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ALU control decode: resolves the per-state ALU function (ADD, SUB or
// instruction-defined FUNCT) into the 2-bit ALU operation code.
module mc_alu_dec
  import mc_pkg::*;
(
  input  alu_fn_e     alu_fn_i,
  input  logic [2:0]  funct3_i,
  input  logic        funct7_5_i,
  input  logic        op5_i,
  output logic [1:0]  alu_ctrl_o
);

  always_comb begin
    // NOTE: assign a default before the case so every path drives the output and no latch is inferred.
    alu_ctrl_o = ALU_ADD;
    case (alu_fn_i)
      FN_SUB: alu_ctrl_o = ALU_SUB;
      FN_FUNCT: begin
        case (funct3_i)
          // instr[30] only selects SUB for register-register ops; addi ignores it.
          3'b000:  alu_ctrl_o = (op5_i && funct7_5_i) ? ALU_SUB : ALU_ADD;
          3'b111:  alu_ctrl_o = ALU_AND;
          3'b110:  alu_ctrl_o = ALU_OR;
          default: alu_ctrl_o = ALU_ADD;
        endcase
      end
      default: alu_ctrl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I controller: a single state register plus combinational
// decode of every datapath enable and mux select.
module mc_control_fsm
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCwrite,
  output logic       IRwrite,
  output logic       AdrSrc,
  output logic       memwr,
  output logic       regwr,
  output logic [1:0] ALUsrcA,
  output logic [1:0] ALUsrcB,
  output logic [1:0] ALUctrl,
  output logic [1:0] resultsrc,
  output logic [1:0] immsrc,
  output logic       illegal_op
);

  state_e  state_q, state_d;
  alu_fn_e alu_fn;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    PCwrite    = 1'b0;
    IRwrite    = 1'b0;
    AdrSrc     = 1'b0;
    memwr      = 1'b0;
    regwr      = 1'b0;
    illegal_op = 1'b0;
    ALUsrcA    = SRCA_PC;
    ALUsrcB    = SRCB_RD2;
    resultsrc  = RES_ALUOUT;
    alu_fn     = FN_ADD;

    case (state_q)
      S_FETCH: begin
        ALUsrcB   = SRCB_FOUR;
        resultsrc = RES_ALU;
        PCwrite   = mem_ready;
        IRwrite   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Branch/jal target is precomputed here from OldPC + imm.
        ALUsrcA = SRCA_OLDPC;
        ALUsrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXEC_R;
          OP_IMM:            state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUsrcA = SRCA_RD1;
        ALUsrcB = SRCB_IMM;
        state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        resultsrc = RES_MEMDATA;
        regwr     = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        memwr  = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC_R: begin
        ALUsrcA = SRCA_RD1;
        ALUsrcB = SRCB_RD2;
        alu_fn  = FN_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXEC_I: begin
        ALUsrcA = SRCA_RD1;
        ALUsrcB = SRCB_IMM;
        alu_fn  = FN_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regwr   = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        // funct3[0] flips the sense of the zero flag: beq takes on zero, bne on non-zero.
        ALUsrcA = SRCA_RD1;
        alu_fn  = FN_SUB;
        PCwrite = zero ^ funct3[0];
        state_d = S_FETCH;
      end
      S_JAL: begin
        ALUsrcA = SRCA_OLDPC;
        ALUsrcB = SRCB_FOUR;
        PCwrite = 1'b1;
        state_d = S_ALUWB;
      end
      S_JALR: begin
        ALUsrcA = SRCA_RD1;
        ALUsrcB = SRCB_IMM;
        state_d = S_JALR_LINK;
      end
      S_JALR_LINK: begin
        // PC takes the target from ALUOut while the ALU forms the link value.
        ALUsrcA = SRCA_OLDPC;
        ALUsrcB = SRCB_FOUR;
        PCwrite = 1'b1;
        state_d = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset wins over everything: no architectural side effect in the abort cycle.
    if (rst) begin
      state_d    = S_FETCH;
      PCwrite    = 1'b0;
      IRwrite    = 1'b0;
      AdrSrc     = 1'b0;
      memwr      = 1'b0;
      regwr      = 1'b0;
      illegal_op = 1'b0;
      ALUsrcA    = SRCA_PC;
      ALUsrcB    = SRCB_RD2;
      resultsrc  = RES_ALUOUT;
      alu_fn     = FN_ADD;
    end
  end

  assign immsrc = imm_sel(op);

  mc_alu_dec u_alu_dec (
    .alu_fn_i   (alu_fn),
    .funct3_i   (funct3),
    .funct7_5_i (funct7_5),
    .op5_i      (op[5]),
    .alu_ctrl_o (ALUctrl)
  );

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: a directed vector table, hand-written multi-cycle
// sequences, and random instruction streams checked against a per-instruction script model.
module tb_mc_control_fsm;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IT   = 7'b0010011;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] BAD  = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = RT;
  logic [2:0] funct3 = 3'b000;
  logic       funct7_5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       PCwrite, IRwrite, AdrSrc, memwr, regwr, illegal_op;
  logic [1:0] ALUsrcA, ALUsrcB, ALUctrl, resultsrc, immsrc;

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct3     (funct3),
    .funct7_5   (funct7_5),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .PCwrite    (PCwrite),
    .IRwrite    (IRwrite),
    .AdrSrc     (AdrSrc),
    .memwr      (memwr),
    .regwr      (regwr),
    .ALUsrcA    (ALUsrcA),
    .ALUsrcB    (ALUsrcB),
    .ALUctrl    (ALUctrl),
    .resultsrc  (resultsrc),
    .immsrc     (immsrc),
    .illegal_op (illegal_op)
  );

  typedef struct packed {
    logic       pcw, irw, adr, memwr, regwr, ill;
    logic [1:0] a, b, ctrl, res, imm;
  } outs_t;

  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f75, zero, rdy;
    outs_t      exp;
    bit         dc;
  } vec_t;

  typedef struct {
    outs_t o;
    bit    waits;
    bit    strobe;
  } phase_t;

  vec_t   vecs[$];
  phase_t prog[$];
  int     applied = 0;
  int     miscompares = 0;

  function automatic outs_t mk(input logic pcw, irw, adr, mw, rw, ill,
                               input logic [1:0] a, b, ctrl, res, imm);
    mk = '{pcw, irw, adr, mw, rw, ill, a, b, ctrl, res, imm};
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == SW)  return 2'b01;
    if (o == BR)  return 2'b10;
    if (o == JAL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [1:0] funct_of(input logic [6:0] o, input logic [2:0] f3, input logic f75);
    if (f3 == 3'b000) return (o[5] && f75) ? 2'b01 : 2'b00;
    if (f3 == 3'b111) return 2'b10;
    if (f3 == 3'b110) return 2'b11;
    return 2'b00;
  endfunction

  function automatic bit legal(input logic [6:0] o);
    return o == LW || o == SW || o == RT || o == IT || o == BR || o == JAL || o == JALR;
  endfunction

  function automatic outs_t o_fetch(input logic rdy, input logic [1:0] imm);
    return mk(rdy, rdy, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, imm);
  endfunction

  function automatic outs_t o_decode(input logic [1:0] imm, input logic ill);
    return mk(0, 0, 0, 0, 0, ill, 2'b01, 2'b01, 2'b00, 2'b00, imm);
  endfunction

  function automatic outs_t o_wb(input logic [1:0] imm);
    return mk(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, imm);
  endfunction

  function automatic outs_t o_addr(input logic [1:0] imm);
    return mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, imm);
  endfunction

  function automatic outs_t dut_outs();
    return mk(PCwrite, IRwrite, AdrSrc, memwr, regwr, illegal_op,
              ALUsrcA, ALUsrcB, ALUctrl, resultsrc, immsrc);
  endfunction

  function automatic void add(input logic r, input logic [6:0] o, input logic [2:0] f3,
                              input logic f75, input logic z, input logic rdy,
                              input outs_t exp, input bit dc);
    vec_t v;
    v.rst = r; v.op = o; v.f3 = f3; v.f75 = f75; v.zero = z; v.rdy = rdy;
    v.exp = exp; v.dc = dc;
    vecs.push_back(v);
  endfunction

  // Per-instruction script of expected cycles; memory phases repeat while not ready.
  function automatic void build(input logic [6:0] o, input logic [2:0] f3, input logic f75, input logic z);
    logic [1:0] imm;
    logic [1:0] fn;
    imm = imm_of(o);
    fn  = funct_of(o, f3, f75);
    prog.delete();
    prog.push_back('{o_fetch(0, imm), 1'b1, 1'b1});
    prog.push_back('{o_decode(imm, !legal(o)), 1'b0, 1'b0});
    if (o == LW) begin
      prog.push_back('{o_addr(imm), 1'b0, 1'b0});
      prog.push_back('{mk(0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, imm), 1'b1, 1'b0});
      prog.push_back('{mk(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, imm), 1'b0, 1'b0});
    end else if (o == SW) begin
      prog.push_back('{o_addr(imm), 1'b0, 1'b0});
      prog.push_back('{mk(0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, imm), 1'b1, 1'b0});
    end else if (o == RT || o == IT) begin
      prog.push_back('{mk(0, 0, 0, 0, 0, 0, 2'b10, (o == IT) ? 2'b01 : 2'b00, fn, 2'b00, imm), 1'b0, 1'b0});
      prog.push_back('{o_wb(imm), 1'b0, 1'b0});
    end else if (o == BR) begin
      prog.push_back('{mk(z ^ f3[0], 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b01, 2'b00, imm), 1'b0, 1'b0});
    end else if (o == JAL) begin
      prog.push_back('{mk(1, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 2'b00, imm), 1'b0, 1'b0});
      prog.push_back('{o_wb(imm), 1'b0, 1'b0});
    end else if (o == JALR) begin
      prog.push_back('{o_addr(imm), 1'b0, 1'b0});
      prog.push_back('{mk(1, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 2'b00, imm), 1'b0, 1'b0});
      prog.push_back('{o_wb(imm), 1'b0, 1'b0});
    end
  endfunction

  task automatic check(input string name, input outs_t exp, input bit dc);
    outs_t act, e;
    act = dut_outs();
    e   = exp;
    if (dc) begin
      act.ctrl = 2'b00; act.imm = 2'b00;
      e.ctrl   = 2'b00; e.imm   = 2'b00;
    end
    applied++;
    if (act !== e) begin
      miscompares++;
      $display("FAIL %s: got %b want %b (pcw irw adr memwr regwr ill A[2] B[2] ctrl[2] res[2] imm[2])",
               name, act, e);
    end
  endtask

  task automatic step(input string name, input logic r, input logic [6:0] o, input logic [2:0] f3,
                      input logic f75, input logic z, input logic rdy, input outs_t exp, input bit dc);
    @(posedge clk);
    #1;
    rst = r; op = o; funct3 = f3; funct7_5 = f75; zero = z; mem_ready = rdy;
    @(negedge clk);
    check(name, exp, dc);
  endtask

  initial begin
    outs_t z0;
    z0 = '0;

    add(1, RT, 3'd0, 0, 0, 1, z0, 1);
    add(1, RT, 3'd0, 0, 0, 1, z0, 1);
    add(0, RT, 3'd0, 0, 0, 1, o_fetch(1, 2'b00), 0);
    add(0, RT, 3'd0, 0, 0, 1, o_decode(2'b00, 0), 0);
    add(0, RT, 3'd0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00), 0);
    add(0, RT, 3'd0, 0, 0, 1, o_wb(2'b00), 0);
    add(0, BR, 3'd0, 0, 1, 1, o_fetch(1, 2'b10), 0);
    add(0, BR, 3'd0, 0, 1, 1, o_decode(2'b10, 0), 0);
    add(0, BR, 3'd0, 0, 1, 1, mk(1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10), 0);
    add(0, BR, 3'd1, 0, 1, 1, o_fetch(1, 2'b10), 0);
    add(0, BR, 3'd1, 0, 1, 1, o_decode(2'b10, 0), 0);
    add(0, BR, 3'd1, 0, 1, 1, mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10), 0);
    add(0, JALR, 3'd0, 0, 0, 1, o_fetch(1, 2'b00), 0);
    add(0, JALR, 3'd0, 0, 0, 1, o_decode(2'b00, 0), 0);
    add(0, JALR, 3'd0, 0, 0, 1, o_addr(2'b00), 0);
    add(0, JALR, 3'd0, 0, 0, 1, mk(1, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00), 0);
    add(0, JALR, 3'd0, 0, 0, 1, o_wb(2'b00), 0);
    add(0, BAD, 3'd0, 0, 0, 1, o_fetch(1, 2'b00), 0);
    add(0, BAD, 3'd0, 0, 0, 1, o_decode(2'b00, 1), 0);
    add(0, IT, 3'd0, 1, 0, 1, o_fetch(1, 2'b00), 0);
    add(0, IT, 3'd0, 1, 0, 1, o_decode(2'b00, 0), 0);
    add(0, IT, 3'd0, 1, 0, 1, mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00), 0);
    add(0, IT, 3'd0, 1, 0, 1, o_wb(2'b00), 0);

    for (int i = 0; i < vecs.size(); i++)
      step($sformatf("tbl[%0d]", i), vecs[i].rst, vecs[i].op, vecs[i].f3, vecs[i].f75,
           vecs[i].zero, vecs[i].rdy, vecs[i].exp, vecs[i].dc);

    // lw with three not-ready cycles in MEMREAD: 8 cycles total.
    step("lw.fetch",  0, LW, 3'd2, 0, 0, 1, o_fetch(1, 2'b00), 0);
    step("lw.decode", 0, LW, 3'd2, 0, 0, 1, o_decode(2'b00, 0), 0);
    step("lw.memadr", 0, LW, 3'd2, 0, 0, 1, o_addr(2'b00), 0);
    for (int i = 0; i < 4; i++)
      step($sformatf("lw.memread%0d", i), 0, LW, 3'd2, 0, 0, (i == 3),
           mk(0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00), 0);
    step("lw.memwb",  0, LW, 3'd2, 0, 0, 0, mk(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00), 0);

    // sw with two not-ready cycles: memwr held three cycles.
    step("sw.fetch",  0, SW, 3'd2, 0, 0, 1, o_fetch(1, 2'b01), 0);
    step("sw.decode", 0, SW, 3'd2, 0, 0, 1, o_decode(2'b01, 0), 0);
    step("sw.memadr", 0, SW, 3'd2, 0, 0, 1, o_addr(2'b01), 0);
    for (int i = 0; i < 3; i++)
      step($sformatf("sw.memwrite%0d", i), 0, SW, 3'd2, 0, 0, (i == 2),
           mk(0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01), 0);

    // Reset during MEMWRITE aborts the store; FETCH follows.
    step("abort.fetch",    0, SW, 3'd2, 0, 0, 1, o_fetch(1, 2'b01), 0);
    step("abort.decode",   0, SW, 3'd2, 0, 0, 1, o_decode(2'b01, 0), 0);
    step("abort.memadr",   0, SW, 3'd2, 0, 0, 1, o_addr(2'b01), 0);
    step("abort.memwrite", 0, SW, 3'd2, 0, 0, 0, mk(0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01), 0);
    step("abort.rst",      1, SW, 3'd2, 0, 0, 1, z0, 1);
    step("abort.refetch",  0, SW, 3'd2, 0, 0, 0, o_fetch(0, 2'b01), 0);

    // Random instruction stream; the DUT is in FETCH here.
    for (int n = 0; n < 300; n++) begin
      logic [6:0] o;
      logic [2:0] f3;
      logic       f75, z;
      case ($urandom_range(0, 7))
        0: o = LW;
        1: o = SW;
        2: o = RT;
        3: o = IT;
        4: o = BR;
        5: o = JAL;
        6: o = JALR;
        default: begin
          o = 7'($urandom);
          if (legal(o)) o = 7'b0000000;
        end
      endcase
      f3  = 3'($urandom);
      f75 = 1'($urandom);
      z   = 1'($urandom);
      build(o, f3, f75, z);
      for (int p = 0; p < prog.size(); p++) begin
        int   tries;
        logic rdy;
        outs_t e;
        tries = 0;
        do begin
          rdy = ($urandom_range(0, 3) != 0) || (tries >= 4);
          e = prog[p].o;
          if (prog[p].strobe) begin
            e.pcw = rdy;
            e.irw = rdy;
          end
          step($sformatf("rand%0d.op%b.p%0d", n, o, p), 0, o, f3, f75, z, rdy, e, 0);
          tries++;
        end while (prog[p].waits && !rdy);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
